alarm_ctrl: RTL and testbench



---
 rtl/alarm_ctrl_pkg.sv | 15 +
 rtl/alarm_ctrl_if.sv | 9 +
 rtl/alarm_ctrl_regs.sv | 59 +++++
 rtl/alarm_ctrl.sv | 124 ++++++++++++
 tb/tb_alarm_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared state encodings and register addresses for the alarm unit
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam logic [3:0] ADDR_ALM_HOUR = 4'hA;
  localparam logic [3:0] ADDR_ALM_MIN  = 4'hB;
  localparam logic [3:0] ADDR_ALM_CTRL = 4'hC;

endpackage

// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - CPU write bus shared with the time-of-day counter
interface alarm_ctrl_if;
  logic        w_en_n;
  logic [15:0] addr;
  logic [7:0]  t;

  modport master (output w_en_n, addr, t);
  modport slave  (input  w_en_n, addr, t);
endinterface

// File: rtl/alarm_ctrl_regs.sv
// rtl/alarm_ctrl_regs.sv - CPU write decode, alarm time/enable registers and control strobes
module alarm_ctrl_regs
  import alarm_ctrl_pkg::*;
(
  input  logic         clock,
  input  logic         rst_n,
  alarm_ctrl_if.slave  bus,
  output logic [5:0]   alarm_hour_o,
  output logic [5:0]   alarm_minute_o,
  output logic         enable_o,
  output logic         en_clr_o,
  output logic         irq_clr_o
);

  logic [5:0] alarm_hour_q, alarm_hour_d;
  logic [5:0] alarm_minute_q, alarm_minute_d;
  logic       enable_q, enable_d;
  logic       wr_hour, wr_min, wr_ctrl;
  logic       unused_bus_bits;

  // Only the low nibble of the address and the low data bits carry meaning here.
  assign unused_bus_bits = ^{bus.addr[15:4], bus.t[7:6]};

  assign wr_hour = !bus.w_en_n && (bus.addr[3:0] == ADDR_ALM_HOUR);
  assign wr_min  = !bus.w_en_n && (bus.addr[3:0] == ADDR_ALM_MIN);
  assign wr_ctrl = !bus.w_en_n && (bus.addr[3:0] == ADDR_ALM_CTRL);

  // Strobes act in the write cycle so the FSM sees them at the same edge the register updates.
  assign en_clr_o  = wr_ctrl && !bus.t[0];
  assign irq_clr_o = wr_ctrl && bus.t[1];

  // Next-state for the programmable registers; out-of-range times are stored as written.
  always_comb begin
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    enable_d       = enable_q;
    if (wr_hour) alarm_hour_d   = bus.t[5:0];
    if (wr_min)  alarm_minute_d = bus.t[5:0];
    if (wr_ctrl) enable_d       = bus.t[0];
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hour_q   <= 6'd0;
      alarm_minute_q <= 6'd0;
      enable_q       <= 1'b0;
    end else begin
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      enable_q       <= enable_d;
    end
  end

  assign alarm_hour_o   = alarm_hour_q;
  assign alarm_minute_o = alarm_minute_q;
  assign enable_o       = enable_q;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm FSM with match detect, snooze and auto-silence counters
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3
) (
  input  logic         clock,
  input  logic         rst_n,
  alarm_ctrl_if.slave  bus,
  input  logic [5:0]   hour,
  input  logic [5:0]   minute,
  input  logic         stop,
  input  logic         snooze,
  output logic         ring,
  output logic         irq,
  output logic [1:0]   state
);

  localparam logic [5:0] RING_LAST   = 6'(RING_MIN - 1);
  localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);

  logic [5:0]   alarm_hour, alarm_minute;
  logic         enable, en_clr, irq_clr;
  logic [5:0]   minute_q;
  logic         match, match_q, match_rise, tick;
  alarm_state_e state_q;
  logic         ring_q, irq_q;
  logic [5:0]   ring_cnt_q, snz_cnt_q;

  alarm_ctrl_regs u_regs (
    .clock          (clock),
    .rst_n          (rst_n),
    .bus            (bus),
    .alarm_hour_o   (alarm_hour),
    .alarm_minute_o (alarm_minute),
    .enable_o       (enable),
    .en_clr_o       (en_clr),
    .irq_clr_o      (irq_clr)
  );

  assign match      = (hour == alarm_hour) && (minute == alarm_minute);
  assign match_rise = match && !match_q;
  assign tick       = (minute != minute_q);

  // Edge history for match and minute; a held match never re-fires.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      match_q  <= 1'b0;
      minute_q <= 6'd0;
    end else begin
      match_q  <= match;
      minute_q <= minute;
    end
  end

  // Alarm FSM: disable beats stop beats snooze beats minute ticks beats a new match; irq set beats clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ring_q     <= 1'b0;
      irq_q      <= 1'b0;
      ring_cnt_q <= 6'd0;
      snz_cnt_q  <= 6'd0;
    end else begin
      if (irq_clr) irq_q <= 1'b0;
      if (en_clr) begin
        state_q <= ST_IDLE;
        ring_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (enable) state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (match_rise) begin
              state_q    <= ST_RINGING;
              ring_q     <= 1'b1;
              irq_q      <= 1'b1;
              ring_cnt_q <= 6'd0;
            end
          end
          ST_RINGING: begin
            if (stop) begin
              state_q <= ST_ARMED;
              ring_q  <= 1'b0;
            end else if (snooze) begin
              state_q   <= ST_SNOOZE;
              ring_q    <= 1'b0;
              snz_cnt_q <= 6'd0;
            end else if (tick) begin
              if (ring_cnt_q == RING_LAST) begin
                state_q <= ST_ARMED;
                ring_q  <= 1'b0;
              end else begin
                ring_cnt_q <= ring_cnt_q + 6'd1;
              end
            end
          end
          ST_SNOOZE: begin
            if (stop) begin
              state_q <= ST_ARMED;
            end else if (tick) begin
              if (snz_cnt_q == SNOOZE_LAST) begin
                state_q    <= ST_RINGING;
                ring_q     <= 1'b1;
                irq_q      <= 1'b1;
                ring_cnt_q <= 6'd0;
              end else begin
                snz_cnt_q <= snz_cnt_q + 6'd1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ring  = ring_q;
  assign irq   = irq_q;
  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed and randomized bench for alarm_ctrl with deadline-based reference model
module tb_alarm_ctrl;
  import alarm_ctrl_pkg::*;

  localparam int SNZ = 5;
  localparam int RNG = 3;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] hour = 6'd0;
  logic [5:0] minute = 6'd0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ring, irq;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  alarm_ctrl_if bus_if ();

  always #5 clock = ~clock;

  alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_MIN(RNG)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .bus    (bus_if.slave),
    .hour   (hour),
    .minute (minute),
    .stop   (stop),
    .snooze (snooze),
    .ring   (ring),
    .irq    (irq),
    .state  (state)
  );

  // Reference model: modes plus absolute minute-tick deadlines instead of per-state counters.
  int         m_mode;
  logic       m_irq;
  logic [5:0] m_ah, m_am, m_prev;
  logic       m_en, m_match_prev;
  int         m_ticks, m_ring_start, m_snz_start;

  task automatic model_reset();
    m_mode = 0; m_irq = 1'b0; m_ah = 6'd0; m_am = 6'd0; m_prev = 6'd0;
    m_en = 1'b0; m_match_prev = 1'b0; m_ticks = 0; m_ring_start = 0; m_snz_start = 0;
  endtask

  task automatic model_step();
    logic tk, mt, rise, wr, en0, clr, set_irq;
    logic [3:0] a;
    tk = (minute != m_prev);
    m_prev = minute;
    if (tk) m_ticks++;
    mt = (hour == m_ah) && (minute == m_am);
    rise = mt && !m_match_prev;
    m_match_prev = mt;
    wr = !bus_if.w_en_n;
    a = bus_if.addr[3:0];
    en0 = wr && (a == 4'hC) && !bus_if.t[0];
    clr = wr && (a == 4'hC) && bus_if.t[1];
    set_irq = 1'b0;
    if (en0) m_mode = 0;
    else if (m_mode == 0) begin
      if (m_en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin m_mode = 2; set_irq = 1'b1; m_ring_start = m_ticks; end
    end else if (m_mode == 2) begin
      if (stop) m_mode = 1;
      else if (snooze) begin m_mode = 3; m_snz_start = m_ticks; end
      else if (tk && m_ticks == m_ring_start + RNG) m_mode = 1;
    end else begin
      if (stop) m_mode = 1;
      else if (tk && m_ticks == m_snz_start + SNZ) begin
        m_mode = 2; set_irq = 1'b1; m_ring_start = m_ticks;
      end
    end
    if (set_irq) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    if (wr && a == 4'hA) m_ah = bus_if.t[5:0];
    if (wr && a == 4'hB) m_am = bus_if.t[5:0];
    if (wr && a == 4'hC) m_en = bus_if.t[0];
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clock);
    #1;
    chk({tag, ".ring"}, 8'(ring), 8'(m_mode == 2));
    chk({tag, ".irq"}, 8'(irq), 8'(m_irq));
    chk({tag, ".state"}, 8'(state), 8'(m_mode));
    stop = 1'b0;
    snooze = 1'b0;
    bus_if.w_en_n = 1'b1;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [7:0] d);
    bus_if.addr = {12'($urandom), a};
    bus_if.t = d;
    bus_if.w_en_n = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    set_wr(a, d);
    cycle("wr");
  endtask

  task automatic set_time(input logic [5:0] h, input logic [5:0] m, input string tag);
    hour = h;
    minute = m;
    cycle(tag);
  endtask

  initial begin
    bus_if.w_en_n = 1'b1;
    bus_if.addr = 16'h0;
    bus_if.t = 8'h0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset.ring", 8'(ring), 8'd0);
    chk("reset.irq", 8'(irq), 8'd0);
    chk("reset.state", 8'(state), 8'(ST_IDLE));
    rst_n = 1'b1;

    // Program alarm 7:30 and enable.
    hour = 6'd7; minute = 6'd29;
    cycle("pre");
    wr(ADDR_ALM_HOUR, 8'd7);
    wr(ADDR_ALM_MIN, 8'd30);
    wr(ADDR_ALM_CTRL, 8'h01);
    cycle("arm");
    chk("armed.state", 8'(state), 8'(ST_ARMED));
    set_time(7, 30, "rise");
    chk("rise.ring", 8'(ring), 8'd1);
    chk("rise.irq", 8'(irq), 8'd1);
    chk("rise.state", 8'(state), 8'(ST_RINGING));

    // Auto-silence after RING_MIN ticks.
    set_time(7, 31, "r31");
    set_time(7, 32, "r32");
    chk("r32.ring", 8'(ring), 8'd1);
    set_time(7, 33, "r33");
    chk("silence.ring", 8'(ring), 8'd0);
    chk("silence.state", 8'(state), 8'(ST_ARMED));
    chk("silence.irq", 8'(irq), 8'd1);
    wr(ADDR_ALM_CTRL, 8'h03);
    chk("irqclr.irq", 8'(irq), 8'd0);
    chk("irqclr.state", 8'(state), 8'(ST_ARMED));

    // Snooze then re-ring SNOOZE_MIN ticks later.
    set_time(7, 29, "s29");
    set_time(7, 30, "s30");
    wr(ADDR_ALM_CTRL, 8'h03);
    chk("snzpre.irq", 8'(irq), 8'd0);
    snooze = 1'b1;
    cycle("snz");
    chk("snz.state", 8'(state), 8'(ST_SNOOZE));
    chk("snz.ring", 8'(ring), 8'd0);
    for (int m = 31; m <= 34; m++) set_time(7, 6'(m), "snzwait");
    chk("snz34.state", 8'(state), 8'(ST_SNOOZE));
    set_time(7, 35, "rering");
    chk("rering.state", 8'(state), 8'(ST_RINGING));
    chk("rering.irq", 8'(irq), 8'd1);

    // Stop beats snooze.
    stop = 1'b1; snooze = 1'b1;
    cycle("stopsnz");
    chk("stopsnz.state", 8'(state), 8'(ST_ARMED));
    chk("stopsnz.ring", 8'(ring), 8'd0);

    // Disable beats snooze; no ring while idle.
    set_time(7, 29, "d29");
    set_time(7, 30, "d30");
    snooze = 1'b1;
    set_wr(ADDR_ALM_CTRL, 8'h00);
    cycle("dis");
    chk("dis.state", 8'(state), 8'(ST_IDLE));
    chk("dis.ring", 8'(ring), 8'd0);
    set_time(7, 29, "i29");
    set_time(7, 30, "i30");
    cycle("i30b");
    chk("idle.ring", 8'(ring), 8'd0);

    // Held match after stop never re-fires.
    wr(ADDR_ALM_CTRL, 8'h01);
    cycle("rearm");
    set_time(7, 29, "h29");
    set_time(7, 30, "h30");
    stop = 1'b1;
    cycle("hstop");
    for (int i = 0; i < 1000; i++) cycle("hold");
    chk("hold.ring", 8'(ring), 8'd0);

    // Asynchronous reset while ringing.
    set_time(7, 29, "x29");
    set_time(7, 30, "x30");
    chk("prerst.ring", 8'(ring), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.ring", 8'(ring), 8'd0);
    chk("arst.irq", 8'(irq), 8'd0);
    chk("arst.state", 8'(state), 8'(ST_IDLE));
    @(posedge clock);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Randomized rounds against the model.
    for (int r = 0; r < 8; r++) begin
      logic [5:0] ah, am;
      ah = 6'($urandom_range(0, 23));
      am = 6'($urandom_range(3, 50));
      wr(ADDR_ALM_HOUR, {2'b00, ah});
      wr(ADDR_ALM_MIN, {2'b00, am});
      wr(ADDR_ALM_CTRL, {6'd0, 1'($urandom), 1'b1});
      set_time(ah, am - 6'd3, "rjump");
      for (int k = 0; k < 20; k++) begin
        int hold;
        hold = $urandom_range(1, 3);
        for (int c = 0; c < hold; c++) begin
          stop = ($urandom_range(0, 19) == 0);
          snooze = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 29) == 0) set_wr(4'($urandom_range(9, 13)), 8'($urandom));
          cycle("rnd");
        end
        if (minute == 6'd59) begin
          minute = 6'd0;
          hour = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        end else begin
          minute = minute + 6'd1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
